// File: rtl/non_res_div_param_if.sv
// non_res_div_param_if: start/done handshake bundle for the non-restoring divider
interface non_res_div_param_if #(parameter int WIDTH = 8);
  logic start;
  logic signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic dbz;
  logic ovf;
  modport master(output start, signed_mode, dividend, divisor,
                 input busy, done, quotient, remainder, dbz, ovf);
  modport slave(input start, signed_mode, dividend, divisor,
                output busy, done, quotient, remainder, dbz, ovf);
endinterface

// File: rtl/non_res_div_param.sv
// non_res_div_param: multi-cycle signed/unsigned non-restoring divider with dbz/ovf flags
module non_res_div_param #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic rst,
  non_res_div_param_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ITER, CORR, SIGN, DONE} state_t;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0] a, m, a_sh, a_new;
  logic [WIDTH-1:0] q, dvd_mag, dvs_mag;
  logic sq, sr, ov, zero, last;
  always_comb begin
    zero = bus.divisor == '0;
    dvd_mag = bus.signed_mode && bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    dvs_mag = bus.signed_mode && bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    // the dropped top bit of A is recovered by the modular add/sub: the true result fits in WIDTH+1 bits
    a_sh = {a[WIDTH-1:0], q[WIDTH-1]};
    a_new = a[WIDTH] ? a_sh + m : a_sh - m;
    last = cnt == CNT_W'(WIDTH - 1);
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.start ? (zero ? DONE : ITER) : IDLE;
      ITER: state_nx = last ? CORR : ITER;
      CORR: state_nx = SIGN;
      SIGN: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      a <= '0;
      q <= '0;
      m <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
      ov <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.dbz <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sq <= bus.signed_mode & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          sr <= bus.signed_mode & bus.dividend[WIDTH-1];
          ov <= bus.signed_mode && bus.dividend == MIN && bus.divisor == '1;
          bus.dbz <= zero;
          bus.ovf <= 1'b0;
          a <= '0;
          q <= dvd_mag;
          m <= {1'b0, dvs_mag};
          cnt <= '0;
          if (zero) begin
            bus.quotient <= '1;
            bus.remainder <= bus.dividend;
          end
        end
        ITER: begin
          a <= a_new;
          q <= {q[WIDTH-2:0], ~a_new[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        CORR: if (a[WIDTH]) a <= a + m;
        SIGN: begin
          bus.quotient <= sq ? -q : q;
          bus.remainder <= sr ? -a[WIDTH-1:0] : a[WIDTH-1:0];
          bus.ovf <= ov;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_non_res_div_param.sv
// tb_non_res_div_param: directed and randomized checks of 8- and 16-bit dividers against an arithmetic model
module tb_non_res_div_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  non_res_div_param_if #(.WIDTH(8)) b8();
  non_res_div_param_if #(.WIDTH(16)) b16();
  non_res_div_param #(.WIDTH(8)) dut8(.clk(clk), .rst(rst), .bus(b8.slave));
  non_res_div_param #(.WIDTH(16)) dut16(.clk(clk), .rst(rst), .bus(b16.slave));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic dbz;
    logic ovf;
    int lat;
    int acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t l8, l16, t, zero_e;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit arm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk_e(logic [31:0] q, logic [31:0] r, bit dbz, bit ovf, int lat);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // plain integer division: SV '/' and '%' truncate toward zero, remainder follows dividend
  function automatic exp_t model(int w, bit sm, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint mask, x, y, min;
    mask = (longint'(1) << w) - 1;
    min = (mask + 1) >> 1;
    x = longint'(a);
    y = longint'(b);
    e = mk_e(0, 0, 0, 0, w + 3);
    if (b == 0) begin
      e.q = 32'(mask); e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
      if (sm && a[w-1]) x = x - (mask + 1);
      if (sm && b[w-1]) y = y - (mask + 1);
      e.ovf = sm && x == -min && y == -1;
      e.q = 32'((x / y) & mask);
      e.r = 32'((x % y) & mask);
    end
    return e;
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  always @(negedge clk) if (arm) begin
    if (q8.size() != 0) begin
      chk("busy8", 32'(b8.busy), 1);
      if (b8.done) begin
        chk("quot8", 32'(b8.quotient), q8[0].q);
        chk("rem8", 32'(b8.remainder), q8[0].r);
        chk("dbz8", 32'(b8.dbz), 32'(q8[0].dbz));
        chk("ovf8", 32'(b8.ovf), 32'(q8[0].ovf));
        chk("lat8", 32'(cyc - q8[0].acc + 1), 32'(q8[0].lat));
        l8 = q8.pop_front();
      end else if (cyc - q8[0].acc > q8[0].lat + 4) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout8: no done after %0d cycles, expected %0d", cyc - q8[0].acc, q8[0].lat);
        q8.delete(0);
      end
    end else begin
      chk("idle_busy8", 32'(b8.busy), 0);
      chk("idle_done8", 32'(b8.done), 0);
      chk("hold_quot8", 32'(b8.quotient), l8.q);
      chk("hold_rem8", 32'(b8.remainder), l8.r);
      chk("hold_flags8", {30'd0, b8.dbz, b8.ovf}, {30'd0, l8.dbz, l8.ovf});
    end
    if (q16.size() != 0) begin
      chk("busy16", 32'(b16.busy), 1);
      if (b16.done) begin
        chk("quot16", 32'(b16.quotient), q16[0].q);
        chk("rem16", 32'(b16.remainder), q16[0].r);
        chk("dbz16", 32'(b16.dbz), 32'(q16[0].dbz));
        chk("ovf16", 32'(b16.ovf), 32'(q16[0].ovf));
        chk("lat16", 32'(cyc - q16[0].acc + 1), 32'(q16[0].lat));
        l16 = q16.pop_front();
      end else if (cyc - q16[0].acc > q16[0].lat + 4) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout16: no done after %0d cycles, expected %0d", cyc - q16[0].acc, q16[0].lat);
        q16.delete(0);
      end
    end else begin
      chk("idle_busy16", 32'(b16.busy), 0);
      chk("idle_done16", 32'(b16.done), 0);
      chk("hold_quot16", 32'(b16.quotient), l16.q);
      chk("hold_rem16", 32'(b16.remainder), l16.r);
      chk("hold_flags16", {30'd0, b16.dbz, b16.ovf}, {30'd0, l16.dbz, l16.ovf});
    end
  end

  task automatic go(bit wide, bit sm, logic [31:0] a, logic [31:0] b, exp_t e);
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = wide ? !b16.busy : !b8.busy;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_wait: busy stuck high, required low within 200 cycles");
      return;
    end
    if (wide) begin
      b16.signed_mode = sm; b16.dividend = a[15:0]; b16.divisor = b[15:0]; b16.start = 1'b1;
    end else begin
      b8.signed_mode = sm; b8.dividend = a[7:0]; b8.divisor = b[7:0]; b8.start = 1'b1;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (wide) begin
      b16.start = 1'b0; q16.push_back(e);
    end else begin
      b8.start = 1'b0; q8.push_back(e);
    end
  endtask

  task automatic rnd(bit wide, int n);
    int w;
    logic [31:0] mask, a, b;
    bit sm;
    w = wide ? 16 : 8;
    mask = wide ? 32'hFFFF : 32'hFF;
    for (int i = 0; i < n; i++) begin
      sm = 1'($urandom_range(0, 1));
      a = $urandom & mask;
      b = $urandom & mask;
      case ($urandom_range(0, 9))
        0: b = 0;
        1: begin a = mask ^ (mask >> 1); b = mask; end
        2: b = $urandom_range(1, 3);
        default: ;
      endcase
      go(wide, sm, a, b, model(w, sm, a, b));
    end
  endtask

  initial begin
    bit seen;
    b8.start = 0; b8.signed_mode = 0; b8.dividend = 0; b8.divisor = 0;
    b16.start = 0; b16.signed_mode = 0; b16.dividend = 0; b16.divisor = 0;
    zero_e = mk_e(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    l8 = zero_e;
    l16 = zero_e;
    arm = 1'b1;

    t = model(8, 0, 200, 7);
    chk("model_u200_7_q", t.q, 28);
    chk("model_u200_7_r", t.r, 4);
    t = model(8, 1, 'hF9, 2);
    chk("model_sneg7_2_q", t.q, 'hFD);
    chk("model_sneg7_2_r", t.r, 'hFF);
    t = model(8, 1, 'h80, 'hFF);
    chk("model_ovf_q", t.q, 'h80);
    chk("model_ovf_flag", 32'(t.ovf), 1);
    t = model(16, 0, 65535, 255);
    chk("model_u16_q", t.q, 257);

    go(0, 0, 200, 7, mk_e(28, 4, 0, 0, 11));
    go(0, 1, 'hF9, 2, mk_e('hFD, 'hFF, 0, 0, 11));
    go(0, 1, 7, 'hFE, mk_e('hFD, 1, 0, 0, 11));
    go(0, 0, 'h55, 0, mk_e('hFF, 'h55, 1, 0, 1));
    go(0, 1, 'h55, 0, mk_e('hFF, 'h55, 1, 0, 1));
    go(0, 0, 200, 7, mk_e(28, 4, 0, 0, 11));
    go(0, 1, 'h80, 'hFF, mk_e('h80, 0, 0, 1, 11));
    go(0, 0, 'h80, 'hFF, mk_e(0, 'h80, 0, 0, 11));
    go(1, 0, 65535, 255, mk_e(257, 0, 0, 0, 19));

    go(0, 0, 100, 9, mk_e(11, 1, 0, 0, 11));
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (seen) break;
      seen = b8.done;
      b8.start = 1'b1;
      b8.dividend = 8'($urandom);
      b8.divisor = 8'($urandom);
      b8.signed_mode = 1'($urandom);
    end
    b8.start = 1'b0;

    go(0, 1, 'h9C, 5, mk_e('hEC, 0, 0, 0, 11));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q8.delete();
    q16.delete();
    l8 = zero_e;
    l16 = zero_e;
    go(0, 0, 200, 7, mk_e(28, 4, 0, 0, 11));

    rnd(0, 1200);
    rnd(1, 300);

    for (int k = 0; k < 100 && (q8.size() != 0 || q16.size() != 0); k++) @(negedge clk);
    if (q8.size() != 0 || q16.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d operations still pending, expected 0", q8.size() + q16.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
